// File: rtl/counter_pkg.sv
// Shared counter definitions: default modulus and down-counter state encoding.
package counter_pkg;

  localparam int DEFAULT_N = 16;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_RUN   = 2'd1;
  localparam state_t ST_PAUSE = 2'd2;
  localparam state_t ST_DONE  = 2'd3;

endpackage

// File: rtl/nbit_down_counter.sv
// Loadable down-counting timer with one-shot / auto-reload modes and a one-cycle
// registered terminal-count pulse; load wins over counting, reset wins over everything.
module nbit_down_counter
  import counter_pkg::*;
#(
  parameter int N = DEFAULT_N,
  localparam int W = (N > 1) ? $clog2(N) : 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         enable,
  input  logic         load,
  input  logic [W-1:0] load_value,
  input  logic         auto_reload,
  output logic [W-1:0] counter_out,
  output logic         tc,
  output logic         busy
);

  localparam logic [W-1:0] MAX_VAL = W'(N - 1);

  state_t       state, state_next;
  logic [W-1:0] count_q, count_next;
  logic [W-1:0] reload_q, reload_next;
  logic         tc_q, tc_next;
  logic [W-1:0] load_sat;

  // Only a non-power-of-two modulus can receive an out-of-range load value.
  generate
    if (N == (1 << W)) begin : g_no_sat
      assign load_sat = load_value;
    end else begin : g_sat
      assign load_sat = (load_value > MAX_VAL) ? MAX_VAL : load_value;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      count_q  <= '0;
      reload_q <= '0;
      tc_q     <= 1'b0;
    end else begin
      state    <= state_next;
      count_q  <= count_next;
      reload_q <= reload_next;
      tc_q     <= tc_next;
    end
  end

  // PAUSE with enable high decrements on that same edge, so resuming skips nothing.
  always_comb begin
    state_next  = state;
    count_next  = count_q;
    reload_next = reload_q;
    tc_next     = 1'b0;
    if (load) begin
      count_next  = load_sat;
      reload_next = load_sat;
      state_next  = enable ? ST_RUN : ST_PAUSE;
    end else if (state == ST_RUN || state == ST_PAUSE) begin
      if (!enable) begin
        state_next = ST_PAUSE;
      end else if (count_q != '0) begin
        count_next = count_q - W'(1);
        state_next = ST_RUN;
      end else begin
        tc_next = 1'b1;
        if (auto_reload) begin
          count_next = reload_q;
          state_next = ST_RUN;
        end else begin
          state_next = ST_DONE;
        end
      end
    end
  end

  always_comb begin
    busy        = (state == ST_RUN) || (state == ST_PAUSE);
    counter_out = count_q;
    tc          = tc_q;
  end

endmodule

// File: tb/tb_nbit_down_counter.sv
// Directed self-checking bench for nbit_down_counter (N=16, W=4).
module tb_nbit_down_counter;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         enable;
  logic         load;
  logic [W-1:0] load_value;
  logic         auto_reload;
  logic [W-1:0] counter_out;
  logic         tc;
  logic         busy;

  int tests = 0;
  int fails = 0;

  nbit_down_counter #(.N(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .load        (load),
    .load_value  (load_value),
    .auto_reload (auto_reload),
    .counter_out (counter_out),
    .tc          (tc),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk3(input string tag, input int cnt, input int t, input int b);
    chk({tag, ".cnt"},  int'(counter_out), cnt);
    chk({tag, ".tc"},   int'(tc),          t);
    chk({tag, ".busy"}, int'(busy),        b);
  endtask

  initial begin
    rst = 1'b1; enable = 1'b1; load = 1'b0; load_value = '0; auto_reload = 1'b0;
    #1;
    repeat (3) step();
    chk3("reset", 0, 0, 0);

    // Enable without a prior load must not count.
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      chk3("idle_en", 0, 0, 0);
    end

    // One-shot countdown from 5.
    load = 1'b1; load_value = 4'd5; enable = 1'b1; auto_reload = 1'b0;
    step();
    load = 1'b0;
    chk3("os_load", 5, 0, 1);
    for (int v = 4; v >= 0; v--) begin
      step();
      chk3("os_cnt", v, 0, 1);
    end
    step();
    chk3("os_tc", 0, 1, 0);
    for (int i = 0; i < 10; i++) begin
      step();
      chk3("os_done", 0, 0, 0);
    end

    // Pause at 7 for 5 cycles, then resume.
    load = 1'b1; load_value = 4'd10;
    step();
    load = 1'b0;
    chk3("pz_load", 10, 0, 1);
    for (int v = 9; v >= 7; v--) begin
      step();
      chk3("pz_pre", v, 0, 1);
    end
    enable = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk3("pz_hold", 7, 0, 1);
    end
    enable = 1'b1;
    for (int v = 6; v >= 0; v--) begin
      step();
      chk3("pz_resume", v, 0, 1);
    end
    step();
    chk3("pz_tc", 0, 1, 0);

    // Auto-reload from 3: tc every 4 cycles.
    auto_reload = 1'b1; load = 1'b1; load_value = 4'd3;
    step();
    load = 1'b0;
    chk3("ar_load", 3, 0, 1);
    for (int p = 0; p < 2; p++) begin
      for (int v = 2; v >= 0; v--) begin
        step();
        chk3("ar_cnt", v, 0, 1);
      end
      step();
      chk3("ar_tc", 3, 1, 1);
    end
    auto_reload = 1'b0;
    for (int v = 2; v >= 0; v--) begin
      step();
      chk3("ar_off_cnt", v, 0, 1);
    end
    step();
    chk3("ar_off_tc", 0, 1, 0);
    step();
    chk3("ar_off_done", 0, 0, 0);

    // Load collides with count already at 0 in RUN.
    load = 1'b1; load_value = 4'd2;
    step();
    load = 1'b0;
    chk3("col_load", 2, 0, 1);
    step();
    chk3("col_1", 1, 0, 1);
    step();
    chk3("col_0", 0, 0, 1);
    load = 1'b1; load_value = 4'd12;
    step();
    load = 1'b0;
    chk3("col_reload", 12, 0, 1);
    for (int v = 11; v >= 9; v--) begin
      step();
      chk3("col_run", v, 0, 1);
    end

    // Reset mid-run at count 9.
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk3("rst_mid", 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      step();
      chk3("rst_idle", 0, 0, 0);
    end

    // Auto-reload with value 0: tc on every cycle.
    auto_reload = 1'b1; load = 1'b1; load_value = 4'd0;
    step();
    load = 1'b0;
    chk3("ar0_load", 0, 0, 1);
    for (int i = 0; i < 3; i++) begin
      step();
      chk3("ar0_tc", 0, 1, 1);
    end

    // Load with enable low enters PAUSE; enabling decrements on the first edge.
    auto_reload = 1'b0; enable = 1'b0; load = 1'b1; load_value = 4'd4;
    step();
    load = 1'b0;
    chk3("pl_load", 4, 0, 1);
    step();
    chk3("pl_hold", 4, 0, 1);
    enable = 1'b1;
    step();
    chk3("pl_dec", 3, 0, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
